// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage with HI/LO registers.
// Fixed WIDTH+1 cycle latency; stalls earlier stages via busy while an op runs.
module ex_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Read_Data_1_EX,
    input  logic [WIDTH-1:0] Read_Data_2_EX,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             signed_op_s;
    logic             rs_neg_s, rt_neg_s;
    logic [WIDTH-1:0] rs_mag_s, rt_mag_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ge_s;
    logic [WIDTH-1:0] div_diff_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0] quot_fix_s, rem_fix_s;

    // Operand magnitudes and one iteration of shift-add / restoring divide
    always_comb begin
        signed_op_s = ~op[0];
        rs_neg_s    = signed_op_s & Read_Data_1_EX[WIDTH-1];
        rt_neg_s    = signed_op_s & Read_Data_2_EX[WIDTH-1];
        rs_mag_s    = rs_neg_s ? (-Read_Data_1_EX) : Read_Data_1_EX;
        rt_mag_s    = rt_neg_s ? (-Read_Data_2_EX) : Read_Data_2_EX;
        mul_sum_s   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_q, quo_q[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, mcand_q});
        // A successful subtract always leaves a remainder below the divisor
        div_diff_s  = div_shift_s[WIDTH-1:0] - mcand_q;
        prod_s      = {acc_q, quo_q};
        prod_fix_s  = neg_q ? (-prod_s) : prod_s;
        quot_fix_s  = neg_q ? (-quo_q) : quo_q;
        rem_fix_s   = rem_neg_q ? (-acc_q) : acc_q;
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        mcand_d   = mcand_q;
        rs_d      = rs_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d   = S_RUN;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    is_div_d  = op[1];
                    neg_d     = rs_neg_s ^ rt_neg_s;
                    rem_neg_d = rs_neg_s;
                    rs_d      = Read_Data_1_EX;
                    acc_d     = '0;
                    mcand_d   = op[1] ? rt_mag_s : rs_mag_s;
                    quo_d     = op[1] ? rs_mag_s : rt_mag_s;
                end else if (!start) begin
                    if (mthi_we) begin
                        hi_d = Read_Data_1_EX;
                    end else begin
                        hi_d = hi_q;
                    end
                    if (mtlo_we) begin
                        lo_d = Read_Data_1_EX;
                    end else begin
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    count_d = '0;
                end else begin
                    if (is_div_q) begin
                        acc_d = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_ge_s};
                    end else begin
                        acc_d = mul_sum_s[WIDTH:1];
                        quo_d = {mul_sum_s[0], quo_q[WIDTH-1:1]};
                    end
                    if (count_q == CW'(WIDTH-1)) begin
                        state_d = S_FIX;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                if (flush) begin
                    done_d = 1'b0;
                end else if (!is_div_q) begin
                    done_d = 1'b1;
                    hi_d   = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d   = prod_fix_s[WIDTH-1:0];
                end else if (mcand_q == '0) begin
                    // Divide by zero: hand back the raw dividend, all-ones quotient
                    done_d = 1'b1;
                    hi_d   = rs_q;
                    lo_d   = {WIDTH{1'b1}};
                end else begin
                    done_d = 1'b1;
                    hi_d   = rem_fix_s;
                    lo_d   = quot_fix_s;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mcand_q   <= '0;
            rs_q      <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            mcand_q   <= mcand_d;
            rs_q      <= rs_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: vector table plus
// hand-written sequences for flush, reset, start-while-busy and MTHI/MTLO.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rd1, rd2;
    logic        flush, mthi_we, mtlo_we;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[13];

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .Read_Data_1_EX(rd1), .Read_Data_2_EX(rd2),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Issue one op; returns busy-cycle count and whether done was high right after busy fell.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output logic dn);
        @(negedge clk);
        start = 1'b1; op = o; rd1 = a; rd2 = b;
        @(negedge clk);
        start = 1'b0; rd1 = $urandom; rd2 = $urandom;
        bcyc = 0;
        while (busy === 1'b1 && bcyc < 100) begin
            bcyc++;
            @(negedge clk);
        end
        dn = done;
    endtask

    int          bc;
    logic        dn;
    int          done_seen;
    int          busy_seen;
    logic [31:0] save_hi, save_lo;

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
        vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

        reset = 1'b1; start = 1'b0; op = 2'b00; rd1 = 32'd0; rd2 = 32'd0;
        flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        // Table-driven arithmetic
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, bc, dn);
            check($sformatf("v%0d_busy_cycles", i), bc, 32'd33);
            check($sformatf("v%0d_done", i), {31'd0, dn}, 32'd1);
            check($sformatf("v%0d_hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].exp_lo);
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // MTHI/MTLO in IDLE, both at once
        mthi_we = 1'b1; rd1 = 32'h00001234;
        @(negedge clk);
        mthi_we = 1'b0;
        check("mthi_hi", hi, 32'h00001234);
        mthi_we = 1'b1; mtlo_we = 1'b1; rd1 = 32'hCAFE0001;
        @(negedge clk);
        mthi_we = 1'b0; mtlo_we = 1'b0;
        check("mthi_mtlo_hi", hi, 32'hCAFE0001);
        check("mthi_mtlo_lo", lo, 32'hCAFE0001);
        mtlo_we = 1'b1; rd1 = 32'h00005555;
        @(negedge clk);
        mtlo_we = 1'b0;
        save_hi = hi; save_lo = lo;
        check("mtlo_lo", lo, 32'h00005555);

        // DIVU 100/7 with mtlo_we while busy, then flush at busy cycle 10
        start = 1'b1; op = OP_DIVU; rd1 = 32'd100; rd2 = 32'd7; mthi_we = 1'b1;
        @(negedge clk);
        start = 1'b0; mthi_we = 1'b0;
        check("start_wins_hi", hi, save_hi);
        check("flush_busy_up", {31'd0, busy}, 32'd1);
        mtlo_we = 1'b1; rd1 = 32'hDEADBEEF;
        @(negedge clk);
        mtlo_we = 1'b0;
        check("mtlo_busy_lo", lo, save_lo);
        repeat (8) @(negedge clk);
        check("run_hi_hold", hi, save_hi);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("flush_no_done", done_seen, 32'd0);
        check("flush_hi", hi, save_hi);
        check("flush_lo", lo, save_lo);

        // start together with flush in IDLE is not issued
        start = 1'b1; flush = 1'b1; op = OP_MULTU; rd1 = 32'd3; rd2 = 32'd3;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset mid-op clears hi/lo
        start = 1'b1; op = OP_MULTU; rd1 = 32'd9; rd2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        check("midreset_no_done", done_seen, 32'd0);

        // start held every cycle while busy: only the first op completes
        start = 1'b1; op = OP_MULTU; rd1 = 32'd3; rd2 = 32'd5;
        @(negedge clk);
        rd1 = 32'd2; rd2 = 32'd2; op = OP_MULT;
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_busy_cycles", bc, 32'd33);
        check("ignore_done", {31'd0, done}, 32'd1);
        check("ignore_hi", hi, 32'd0);
        check("ignore_lo", lo, 32'd15);
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        check("ignore_no_second", busy_seen, 32'd0);

        // Back-to-back: start in the done cycle of the previous op
        run_op(OP_DIVU, 32'd50, 32'd6, bc, dn);
        check("b2b_first_done", {31'd0, dn}, 32'd1);
        check("b2b_first_lo", lo, 32'd8);
        start = 1'b1; op = OP_MULTU; rd1 = 32'd11; rd2 = 32'd13;
        @(negedge clk);
        start = 1'b0;
        bc = 0;
        while (busy === 1'b1 && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check("b2b_second_cycles", bc, 32'd33);
        check("b2b_second_done", {31'd0, done}, 32'd1);
        check("b2b_second_hi", hi, 32'd0);
        check("b2b_second_lo", lo, 32'd143);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
